// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side fields, register-file read data, writeback
// bypass source, pipeline control and the captured EX-side outputs.
interface id_ex_stage_if #(
    parameter int CTRL_W   = 8,
    parameter int STALL_CW = 16
);
    // Decode side
    logic                id_valid;
    logic [3:0]          id_rs;
    logic [3:0]          id_rt;
    logic [3:0]          id_rd;
    logic                id_use_rs;
    logic                id_use_rt;
    logic                id_is_load;
    logic                id_wr_reg;
    logic [CTRL_W-1:0]   id_ctrl;
    // Register file read ports and writeback
    logic [15:0]         rf_data1;
    logic [15:0]         rf_data2;
    logic                wb_write;
    logic [3:0]          wb_dst;
    logic [15:0]         wb_data;
    // Pipeline control
    logic                flush;
    logic                hold;
    logic                stall;
    // EX side
    logic                ex_valid;
    logic [15:0]         ex_op1;
    logic [15:0]         ex_op2;
    logic [3:0]          ex_rs;
    logic [3:0]          ex_rt;
    logic [3:0]          ex_rd;
    logic                ex_is_load;
    logic                ex_wr_reg;
    logic [CTRL_W-1:0]   ex_ctrl;
    logic [STALL_CW-1:0] stall_cycles;

    // Upstream / environment view
    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
               id_is_load, id_wr_reg, id_ctrl, rf_data1, rf_data2,
               wb_write, wb_dst, wb_data, flush, hold,
        input  stall, ex_valid, ex_op1, ex_op2, ex_rs, ex_rt, ex_rd,
               ex_is_load, ex_wr_reg, ex_ctrl, stall_cycles
    );

    // Pipeline stage view
    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
               id_is_load, id_wr_reg, id_ctrl, rf_data1, rf_data2,
               wb_write, wb_dst, wb_data, flush, hold,
        output stall, ex_valid, ex_op1, ex_op2, ex_rs, ex_rt, ex_rd,
               ex_is_load, ex_wr_reg, ex_ctrl, stall_cycles
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, R0 zeroing, load-use
// hazard detection (one bubble + IF/ID stall), flush/hold handling and a
// saturating stall-cycle counter.
module id_ex_stage #(
    parameter int CTRL_W   = 8,
    parameter int STALL_CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic        loadUseHaz;
    logic [15:0] op1Next;
    logic [15:0] op2Next;

    // Operand selection: R0 reads zero, else same-cycle writeback wins over regfile
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        op1Next = bus.rf_data1;
        op2Next = bus.rf_data2;
        if (bus.id_rs == 4'd0)
            op1Next = 16'h0000;
        else if (bus.wb_write && (bus.wb_dst == bus.id_rs))
            op1Next = bus.wb_data;
        if (bus.id_rt == 4'd0)
            op2Next = 16'h0000;
        else if (bus.wb_write && (bus.wb_dst == bus.id_rt))
            op2Next = bus.wb_data;
    end

    // Load in EX whose destination is read by the instruction in ID
    assign loadUseHaz = bus.id_valid && bus.ex_valid && bus.ex_is_load &&
                        bus.ex_wr_reg && (bus.ex_rd != 4'd0) &&
                        ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                         (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

    // Stall is forced low while reset is asserted, independent of hold
    assign bus.stall = !rst && (loadUseHaz || bus.hold);

    // ID/EX register: flush > hold > bubble > capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
            bus.ex_valid   <= 1'b0;
            bus.ex_op1     <= '0;
            bus.ex_op2     <= '0;
            bus.ex_rs      <= '0;
            bus.ex_rt      <= '0;
            bus.ex_rd      <= '0;
            bus.ex_is_load <= 1'b0;
            bus.ex_wr_reg  <= 1'b0;
            bus.ex_ctrl    <= '0;
        end else if (bus.flush) begin
            // Squashed slot; flags cleared too so it can never look like a load
            bus.ex_valid   <= 1'b0;
            bus.ex_is_load <= 1'b0;
            bus.ex_wr_reg  <= 1'b0;
        end else if (!bus.hold) begin
            if (loadUseHaz) begin
                // Bubble flags cleared so the bubble cannot re-trigger the hazard
                bus.ex_valid   <= 1'b0;
                bus.ex_is_load <= 1'b0;
                bus.ex_wr_reg  <= 1'b0;
            end else begin
                bus.ex_valid   <= bus.id_valid;
                bus.ex_op1     <= op1Next;
                bus.ex_op2     <= op2Next;
                bus.ex_rs      <= bus.id_rs;
                bus.ex_rt      <= bus.id_rt;
                bus.ex_rd      <= bus.id_rd;
                bus.ex_is_load <= bus.id_is_load;
                bus.ex_wr_reg  <= bus.id_wr_reg;
                bus.ex_ctrl    <= bus.id_ctrl;
            end
        end
    end

    // Saturating count of edges on which stall was asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.stall_cycles <= '0;
        else if (bus.stall && (bus.stall_cycles != '1))
            bus.stall_cycles <= bus.stall_cycles + STALL_CW'(1);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts the ID/EX
// contents after each edge, pushes them to a queue, and the sample taken
// just after the edge pops and compares them.
module tb_id_ex_stage;

    localparam int CTRL_W = 8;

    typedef struct {
        logic        valid;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic        isLoad;
        logic        wrReg;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
        int          level;   // 0: valid only, 1: + flags, 2: every field
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vecCount  = 0;
    int   missCount = 0;
    exp_t sbQueue[$];
    exp_t mdl;

    always #5 clk = ~clk;

    id_ex_stage_if #(.CTRL_W(CTRL_W), .STALL_CW(16)) bus ();
    id_ex_stage_if #(.CTRL_W(CTRL_W), .STALL_CW(2))  satBus ();

    id_ex_stage #(.CTRL_W(CTRL_W), .STALL_CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    id_ex_stage #(.CTRL_W(CTRL_W), .STALL_CW(2)) satDut (
        .clk (clk),
        .rst (rst),
        .bus (satBus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] operand(input logic [3:0] r, input logic [15:0] rfd);
        if (r == 4'd0) return 16'h0000;
        if (bus.wb_write && bus.wb_dst == r) return bus.wb_data;
        return rfd;
    endfunction

    function automatic logic modelHaz();
        return bus.id_valid && mdl.valid && mdl.isLoad && mdl.wrReg && (mdl.rd != 4'd0) &&
               ((bus.id_use_rs && bus.id_rs == mdl.rd) || (bus.id_use_rt && bus.id_rt == mdl.rd));
    endfunction

    task automatic setId(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic useRs, input logic useRt,
                         input logic isLoad, input logic wrReg, input logic [7:0] ctrl,
                         input logic [15:0] d1, input logic [15:0] d2);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_use_rs  = useRs;
        bus.id_use_rt  = useRt;
        bus.id_is_load = isLoad;
        bus.id_wr_reg  = wrReg;
        bus.id_ctrl    = ctrl;
        bus.rf_data1   = d1;
        bus.rf_data2   = d2;
    endtask

    task automatic setWb(input logic w, input logic [3:0] dst, input logic [15:0] data);
        bus.wb_write = w;
        bus.wb_dst   = dst;
        bus.wb_data  = data;
    endtask

    task automatic compareHead(input string tag);
        exp_t e;
        if (sbQueue.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = sbQueue.pop_front();
        check({tag, ".valid"}, bus.ex_valid, e.valid);
        check({tag, ".cnt"}, bus.stall_cycles, e.cnt);
        if (e.level >= 1) begin
            check({tag, ".isLoad"}, bus.ex_is_load, e.isLoad);
            check({tag, ".wrReg"}, bus.ex_wr_reg, e.wrReg);
        end
        if (e.level == 2) begin
            check({tag, ".op1"}, bus.ex_op1, e.op1);
            check({tag, ".op2"}, bus.ex_op2, e.op2);
            check({tag, ".rs"}, bus.ex_rs, e.rs);
            check({tag, ".rt"}, bus.ex_rt, e.rt);
            check({tag, ".rd"}, bus.ex_rd, e.rd);
            check({tag, ".ctrl"}, bus.ex_ctrl, e.ctrl);
        end
    endtask

    // One clock: check combinational stall, predict next state, clock, compare
    task automatic tick(input string tag);
        exp_t nxt;
        logic haz;
        logic expStall;
        #1;
        haz      = modelHaz();
        expStall = haz || bus.hold;
        check({tag, ".stall"}, bus.stall, expStall);
        nxt = mdl;
        if (bus.flush) begin
            nxt.valid = 1'b0;
            nxt.level = 0;
        end else if (bus.hold) begin
            nxt = mdl;
        end else if (haz) begin
            nxt.valid  = 1'b0;
            nxt.isLoad = 1'b0;
            nxt.wrReg  = 1'b0;
            nxt.level  = 1;
        end else begin
            nxt.valid  = bus.id_valid;
            nxt.op1    = operand(bus.id_rs, bus.rf_data1);
            nxt.op2    = operand(bus.id_rt, bus.rf_data2);
            nxt.rs     = bus.id_rs;
            nxt.rt     = bus.id_rt;
            nxt.rd     = bus.id_rd;
            nxt.isLoad = bus.id_is_load;
            nxt.wrReg  = bus.id_wr_reg;
            nxt.ctrl   = bus.id_ctrl;
            nxt.level  = 2;
        end
        if (expStall && nxt.cnt != 16'hFFFF)
            nxt.cnt = nxt.cnt + 16'd1;
        sbQueue.push_back(nxt);
        mdl = nxt;
        @(posedge clk);
        #1;
        compareHead(tag);
    endtask

    task automatic resetModel();
        mdl = '{valid: 1'b0, op1: 16'h0, op2: 16'h0, rs: 4'h0, rt: 4'h0, rd: 4'h0,
                isLoad: 1'b0, wrReg: 1'b0, ctrl: 8'h0, cnt: 16'h0, level: 2};
        sbQueue.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cntBefore;
        rst = 1'b1;
        setId(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
        setWb(1'b0, 4'd0, 16'h0);
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        satBus.id_valid = 1'b0;  satBus.id_rs = 4'd0;  satBus.id_rt = 4'd0;
        satBus.id_rd = 4'd0;     satBus.id_use_rs = 1'b0; satBus.id_use_rt = 1'b0;
        satBus.id_is_load = 1'b0; satBus.id_wr_reg = 1'b0; satBus.id_ctrl = 8'h00;
        satBus.rf_data1 = 16'h0; satBus.rf_data2 = 16'h0; satBus.wb_write = 1'b0;
        satBus.wb_dst = 4'd0;    satBus.wb_data = 16'h0;  satBus.flush = 1'b0;
        satBus.hold = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("resetValid", bus.ex_valid, 1'b0);
        check("resetCnt", bus.stall_cycles, 16'd0);
        check("resetStall", bus.stall, 1'b0);

        // Bypass rs from writeback
        setId(1'b1, 4'd3, 4'd4, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 16'h1111, 16'h2222);
        setWb(1'b1, 4'd3, 16'hBEEF);
        tick("bypassRs");
        check("bypassOp1", bus.ex_op1, 16'hBEEF);
        check("bypassOp2", bus.ex_op2, 16'h2222);

        // Bypass rt from writeback
        setWb(1'b1, 4'd4, 16'hCAFE);
        tick("bypassRt");
        check("bypassRtOp2", bus.ex_op2, 16'hCAFE);

        // R0 reads zero, never bypassed
        setId(1'b1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 16'hFFFF, 16'hFFFF);
        setWb(1'b1, 4'd0, 16'h1234);
        tick("r0");
        check("r0Op1", bus.ex_op1, 16'h0000);
        setWb(1'b0, 4'd0, 16'h0);

        // Load-use: ld R5 then add reading R5
        setId(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 16'h0A0A, 16'h0);
        tick("ldR5");
        setId(1'b1, 4'd5, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 16'h5555, 16'h2222);
        cntBefore = bus.stall_cycles;
        #1;
        check("luStall", bus.stall, 1'b1);
        tick("luBubble");
        check("luBubbleValid", bus.ex_valid, 1'b0);
        check("luCntInc", bus.stall_cycles, cntBefore + 16'd1);
        tick("luIssue");
        check("luIssueRd", bus.ex_rd, 4'd7);
        check("luIssueValid", bus.ex_valid, 1'b1);

        // No hazard: rt matches but is not used
        setId(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 16'h1, 16'h0);
        tick("ldR5b");
        setId(1'b1, 4'd1, 4'd5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 16'h3, 16'h4);
        #1;
        check("noUseRtStall", bus.stall, 1'b0);
        tick("noUseRt");

        // No hazard: load to R0
        setId(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 16'h7, 16'h0);
        tick("ldR0");
        setId(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 16'h8, 16'h9);
        #1;
        check("ldR0Stall", bus.stall, 1'b0);
        tick("useR0");

        // Flush and hold together during a hazard
        setId(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h88, 16'h1, 16'h0);
        tick("ldR5c");
        setId(1'b1, 4'd5, 4'd5, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'h99, 16'hAAAA, 16'hBBBB);
        bus.flush = 1'b1;
        bus.hold  = 1'b1;
        #1;
        check("flushHoldStall", bus.stall, 1'b1);
        tick("flushHold");
        check("flushHoldValid", bus.ex_valid, 1'b0);
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        tick("afterFlush");
        check("afterFlushValid", bus.ex_valid, 1'b1);
        check("afterFlushOp1", bus.ex_op1, 16'hAAAA);

        // Randomised traffic through the model
        for (int i = 0; i < 60; i++) begin
            setId(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  16'($urandom), 16'($urandom));
            setWb(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom));
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.hold  = ($urandom_range(0, 5) == 0);
            tick("rand");
        end
        bus.flush = 1'b0;
        bus.hold  = 1'b0;

        // Asynchronous reset mid-run with a live instruction and hold asserted
        setId(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 16'h1357, 16'h2468);
        setWb(1'b0, 4'd0, 16'h0);
        tick("preReset");
        check("preResetValid", bus.ex_valid, 1'b1);
        bus.hold = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("asyncValid", bus.ex_valid, 1'b0);
        check("asyncOp1", bus.ex_op1, 16'h0);
        check("asyncOp2", bus.ex_op2, 16'h0);
        check("asyncRd", bus.ex_rd, 4'd0);
        check("asyncLoad", bus.ex_is_load, 1'b0);
        check("asyncWr", bus.ex_wr_reg, 1'b0);
        check("asyncCtrl", bus.ex_ctrl, 8'h0);
        check("asyncCnt", bus.stall_cycles, 16'd0);
        check("asyncStall", bus.stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.hold = 1'b0;
        resetModel();

        // Counter saturation on the 2-bit instance
        check("satStart", satBus.stall_cycles, 2'd0);
        satBus.hold = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            check("satCnt", satBus.stall_cycles, (n < 3) ? n : 3);
        end
        satBus.hold = 1'b0;
        @(posedge clk);
        #1;
        check("satHoldOff", satBus.stall_cycles, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
